branch_lut_loader: RTL and testbench
====================================

# branch_lut_loader

Writer side of the branch-target lookup table. Accepts a byte-stream frame of (index, target) pairs from the boot/debug port and stages them in a shadow bank. On a checksum-verified frame it commits them atomically into the active 16-entry table. The fetch stage reads the active table combinationally through `rd_addr`/`rd_target`, with the same semantics as the fixed table it replaces.

## Interface
- `D`, 10: branch-target width; legal range 8..10.
- `clk`  in  1  clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  byte-stream valid.
- `in_ready`  out  1  byte-stream ready.
- `in_data`  in  8  stream byte.
- `rd_addr`  in  4  table index from the fetch stage.
- `rd_target`  out  D  active-table entry at `rd_addr`; combinational.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse on commit.
- `err`  out  1  one-cycle pulse on frame abort.
- `loaded`  out  1  sticky; set by the first commit, cleared only by reset.

## Operation
- Frame format:
  - SOF byte 0xA5.
  - COUNT byte N, legal 1..16.
  - N pairs of `{idx[3:0], 2'b00, tgt[9:8]}` then `tgt[7:0]`.
  - CHK byte: XOR of COUNT and all pair bytes.
- Byte transfer: `in_valid && in_ready` at a rising edge.
- FSM states: IDLE, COUNT, HI, LO, CHK, COMMIT.
  - IDLE: non-SOF bytes are consumed and dropped silently. SOF moves to COUNT and copies the active bank into the shadow bank.
  - COUNT: N=0 or N>16 gives err and returns to IDLE. Otherwise latch N, init checksum=N, go to HI.
  - HI: latch idx and the high target bits, XOR into checksum, go to LO.
  - LO: write the shadow entry, XOR into checksum, decrement the remaining count. Go to HI if pairs remain, else CHK.
  - CHK: on match go to COMMIT. On mismatch pulse err, go to IDLE, leave the active bank untouched.
  - COMMIT: one cycle; copy shadow to active, pulse done, set loaded, go to IDLE.
- Target bits at position D and above in a pair must be zero. Otherwise pulse err when LO is accepted and go to IDLE.
- Bits [3:2] of the HI byte are ignored.
- A duplicate idx in one frame: the last write wins.
- Entries absent from the frame keep their current active value.
- `in_ready` = 1 in every state except COMMIT.
- A SOF byte seen mid-frame is treated as data, not a restart.

## Timing
- Reset values:
  - Active bank = default table: 0, 11, 44, 114, 87, 105, 94, 111, 1, 20, then 0 for entries 10..15.
  - Shadow bank = same defaults.
  - FSM in IDLE; `busy`=0, `done`=0, `err`=0, `loaded`=0, `in_ready`=1.
- `rd_target` is purely combinational from the active bank and `rd_addr`, with zero latency.
- CHK accepted at edge k: COMMIT occupies cycle k→k+1 with `in_ready`=0. At edge k+1 the active bank updates and `done`=1 for exactly one cycle; new `rd_target` values are visible in that same cycle.
- `err` is registered and rises the cycle after the offending byte is accepted.
- Frame throughput: one byte per cycle; N=16 takes 35 byte cycles plus 1 COMMIT cycle.
- Reset asserted mid-frame: the next edge returns everything to reset values, active bank included, and discards the partial frame.
- Reset asserted in the COMMIT cycle: reset wins; no commit.
- `rd_addr` change in the COMMIT cycle: returns the old value; the new value appears from k+1.

## Structure
- Package `branch_lut_pkg`:
  - `LUT_DEPTH`=16.
  - `SOF_BYTE`=8'hA5.
  - Default-table constant array.
  - FSM state enum.
- Sub-module `lut_bank`: 16×D register array with:
  - synchronous write port;
  - synchronous bulk-load input from the other bank;
  - combinational read port;
  - reset to the package defaults.
- Instantiate `lut_bank` twice: shadow and active.

## Test plan
- Reset, then sweep `rd_addr` 0..15 → `rd_target` = 0, 11, 44, 114, 87, 105, 94, 111, 1, 20, 0×6; `loaded`=0.
- Frame A5, 01, 91, 2C, BC (idx 9 → 300) → `done` pulse; `rd_target`[9]=300 from the done cycle; other entries unchanged; `loaded`=1.
- Same frame with CHK=BD → `err` pulse; entry 9 stays 20; `done` never asserted.
- COUNT=00, and separately COUNT=11h → `err` after the COUNT byte; FSM back in IDLE; next valid frame commits normally.
- Frame with N=2 writing idx 3=5 then idx 3=7 (correct CHK) → entry 3 = 7.
- Assert `reset_n`=0 after the HI byte of a frame, then release → defaults restored; `busy`=0; `in_ready`=1. Random `in_valid` gaps during a full 16-entry frame give an identical final table.

Source files
------------

// File: rtl/branch_lut_pkg.sv
// ---------------------------------------------------------------------------
// branch_lut_pkg
// Shared constants and types for the branch-target lookup table loader:
// table depth, frame start-of-frame marker, power-up target table, loader
// FSM state encoding and the running-checksum helper.
// ---------------------------------------------------------------------------
package branch_lut_pkg;

  localparam int LUT_DEPTH = 16;
  localparam int LUT_AW    = 4;
  // Widest target a frame can carry ({2 high bits, 8 low bits}).
  localparam int TGT_MAX_W = 10;

  localparam logic [7:0] SOF_BYTE  = 8'hA5;
  localparam logic [7:0] MAX_COUNT = 8'd16;

  // Power-up contents of both banks; identical to the fixed table this replaces.
  localparam logic [TGT_MAX_W-1:0] DEFAULT_TABLE [LUT_DEPTH] = '{
    10'd0,  10'd11, 10'd44, 10'd114, 10'd87, 10'd105, 10'd94, 10'd111,
    10'd1,  10'd20, 10'd0,  10'd0,   10'd0,  10'd0,   10'd0,  10'd0
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COUNT  = 3'd1,
    ST_HI     = 3'd2,
    ST_LO     = 3'd3,
    ST_CHK    = 3'd4,
    ST_COMMIT = 3'd5
  } lut_state_t;

  // Frame checksum is a byte-wise XOR accumulation.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/lut_bank.sv
// ---------------------------------------------------------------------------
// lut_bank
// One LUT_DEPTH x D bank of branch targets.
//   clk, reset_n          : clock, synchronous active-low reset (loads defaults)
//   wr_en/wr_addr/wr_data : single-entry synchronous write
//   load_en/load_data     : synchronous whole-bank load (flattened, entry i at
//                           bits [i*D +: D]); takes priority over wr_en
//   rd_addr/rd_data       : combinational single-entry read
//   bank_data             : whole bank, flattened, for loading the peer bank
// ---------------------------------------------------------------------------
module lut_bank
  import branch_lut_pkg::*;
#(
  parameter int D = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [LUT_AW-1:0]      wr_addr,
  input  logic [D-1:0]           wr_data,
  input  logic                   load_en,
  input  logic [LUT_DEPTH*D-1:0] load_data,
  input  logic [LUT_AW-1:0]      rd_addr,
  output logic [D-1:0]           rd_data,
  output logic [LUT_DEPTH*D-1:0] bank_data
);

  logic [D-1:0] r_mem [LUT_DEPTH];

  // Storage: reset to defaults, bulk load from the peer bank, or single write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        r_mem[i] <= DEFAULT_TABLE[i][D-1:0];
      end
    end else if (load_en) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        r_mem[i] <= load_data[i*D +: D];
      end
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end else begin
      r_mem <= r_mem;
    end
  end

  assign rd_data = r_mem[rd_addr];

  // Flatten the bank so the peer can copy it in one cycle.
  always_comb begin
    bank_data = '0;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      bank_data[i*D +: D] = r_mem[i];
    end
  end

endmodule

// File: rtl/branch_lut_loader.sv
// ---------------------------------------------------------------------------
// branch_lut_loader
// Parses a byte-stream frame of (index, target) pairs into a shadow bank and,
// once the XOR checksum matches, copies the shadow bank into the active bank
// in a single cycle. The fetch stage reads the active bank combinationally.
//   clk, reset_n        : clock, synchronous active-low reset
//   in_valid/in_ready   : byte-stream handshake, in_data is the byte
//   rd_addr/rd_target   : combinational active-table read
//   busy                : loader FSM not idle
//   done                : one-cycle pulse, active bank just updated
//   err                 : one-cycle pulse, frame aborted
//   loaded              : sticky, at least one commit since reset
// ---------------------------------------------------------------------------
module branch_lut_loader
  import branch_lut_pkg::*;
#(
  parameter int D = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic [LUT_AW-1:0] rd_addr,
  output logic [D-1:0]      rd_target,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              loaded
);

  lut_state_t  r_state, w_state_nxt;
  logic [4:0]  r_remaining, w_remaining_nxt;
  logic [7:0]  r_chk, w_chk_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic [1:0]  r_tgt_hi, w_tgt_hi_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic        r_loaded, w_loaded_nxt;

  logic                   w_fire;
  logic                   w_shadow_we;
  logic                   w_shadow_load;
  logic                   w_active_load;
  logic [TGT_MAX_W-1:0]   w_full_tgt;
  logic                   w_tgt_overflow;
  logic [LUT_DEPTH*D-1:0] w_shadow_flat;
  logic [LUT_DEPTH*D-1:0] w_active_flat;
  logic [D-1:0]           w_shadow_rd_unused;

  assign in_ready = (r_state != ST_COMMIT);
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign err      = r_err;
  assign loaded   = r_loaded;
  assign w_fire   = in_valid && in_ready;

  // Target as carried by the frame; any bit at position D or above is illegal.
  assign w_full_tgt     = {r_tgt_hi, in_data};
  assign w_tgt_overflow = ((w_full_tgt >> D) != 10'd0);

  // Next-state and datapath control for the frame parser.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_chk_nxt       = r_chk;
    w_idx_nxt       = r_idx;
    w_tgt_hi_nxt    = r_tgt_hi;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_loaded_nxt    = r_loaded;
    w_shadow_we     = 1'b0;
    w_shadow_load   = 1'b0;
    w_active_load   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Re-seed the shadow from the active bank so absent entries persist.
        if (w_fire && (in_data == SOF_BYTE)) begin
          w_shadow_load = 1'b1;
          w_state_nxt   = ST_COUNT;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (!w_fire) begin
          w_state_nxt = ST_COUNT;
        end else if ((in_data == 8'd0) || (in_data > MAX_COUNT)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_remaining_nxt = in_data[4:0];
          w_chk_nxt       = in_data;
          w_state_nxt     = ST_HI;
        end
      end
      ST_HI: begin
        if (w_fire) begin
          w_idx_nxt    = in_data[7:4];
          w_tgt_hi_nxt = in_data[1:0];
          w_chk_nxt    = chk_fold(r_chk, in_data);
          w_state_nxt  = ST_LO;
        end else begin
          w_state_nxt  = ST_HI;
        end
      end
      ST_LO: begin
        if (!w_fire) begin
          w_state_nxt = ST_LO;
        end else if (w_tgt_overflow) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_shadow_we     = 1'b1;
          w_chk_nxt       = chk_fold(r_chk, in_data);
          w_remaining_nxt = r_remaining - 5'd1;
          if (r_remaining == 5'd1) begin
            w_state_nxt = ST_CHK;
          end else begin
            w_state_nxt = ST_HI;
          end
        end
      end
      ST_CHK: begin
        if (!w_fire) begin
          w_state_nxt = ST_CHK;
        end else if (in_data == r_chk) begin
          w_state_nxt = ST_COMMIT;
        end else begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        w_active_load = 1'b1;
        w_done_nxt    = 1'b1;
        w_loaded_nxt  = 1'b1;
        w_state_nxt   = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Parser state and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_remaining <= 5'd0;
      r_chk       <= 8'd0;
      r_idx       <= 4'd0;
      r_tgt_hi    <= 2'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_loaded    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_chk       <= w_chk_nxt;
      r_idx       <= w_idx_nxt;
      r_tgt_hi    <= w_tgt_hi_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_loaded    <= w_loaded_nxt;
    end
  end

  lut_bank #(.D(D)) u_shadow (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (w_shadow_we),
    .wr_addr   (r_idx),
    .wr_data   (w_full_tgt[D-1:0]),
    .load_en   (w_shadow_load),
    .load_data (w_active_flat),
    .rd_addr   (4'd0),
    .rd_data   (w_shadow_rd_unused),
    .bank_data (w_shadow_flat)
  );

  lut_bank #(.D(D)) u_active (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (1'b0),
    .wr_addr   (4'd0),
    .wr_data   ({D{1'b0}}),
    .load_en   (w_active_load),
    .load_data (w_shadow_flat),
    .rd_addr   (rd_addr),
    .rd_data   (rd_target),
    .bank_data (w_active_flat)
  );

endmodule

// File: tb/tb_branch_lut_loader.sv
// ---------------------------------------------------------------------------
// tb_branch_lut_loader
// Randomized, scoreboard-checked bench for branch_lut_loader. Each frame's
// outcome (commit or abort, and the resulting table) is predicted from the
// frame bytes and queued; a negedge monitor pops and compares on every
// done/err pulse. Stimulus additionally checks handshake timing and sweeps
// the whole table after each frame.
// ---------------------------------------------------------------------------
module tb_branch_lut_loader;

  localparam int D = 10;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = 8'd0;
  logic [3:0]   rd_addr = 4'd0;
  logic [D-1:0] rd_target;
  logic         busy, done, err, loaded;

  always #5 clk = ~clk;

  branch_lut_loader #(.D(D)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rd_addr   (rd_addr),
    .rd_target (rd_target),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .loaded    (loaded)
  );

  typedef struct {
    bit is_err;
    int tbl[16];
  } exp_t;

  int         n_checks = 0;
  int         n_pass = 0;
  int         model[16];
  int         saved_tbl[16];
  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] frame_q[$];
  logic [7:0] saved_frame[$];
  bit         use_gaps = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    model = '{0, 11, 44, 114, 87, 105, 94, 111, 1, 20, 0, 0, 0, 0, 0, 0};
  endtask

  // Reference: what a frame should do to the table, straight from the frame rules.
  function automatic void predict(output exp_t e);
    int n, tgt, idx;
    logic [7:0] x, hi, lo;
    e.tbl = model;
    e.is_err = 1'b0;
    n = int'(frame_q[1]);
    x = frame_q[1];
    if (n < 1 || n > 16) begin
      e.is_err = 1'b1;
      return;
    end
    for (int p = 0; p < n; p++) begin
      hi  = frame_q[2 + 2*p];
      lo  = frame_q[3 + 2*p];
      x   = x ^ hi ^ lo;
      idx = int'(hi[7:4]);
      tgt = int'(hi[1:0]) * 256 + int'(lo);
      if (tgt >= (1 << D)) begin
        e.is_err = 1'b1;
        return;
      end
      e.tbl[idx] = tgt;
    end
    e.is_err = (frame_q[2 + 2*n] != x);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int guard;
    bit ready_s;
    if (use_gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    rd_addr  = 4'($urandom_range(0, 15));
    guard    = 0;
    forever begin
      ready_s = in_ready;
      @(posedge clk);
      #1;
      if (ready_s) break;
      guard++;
      if (guard > 20) begin
        check("byte_accept_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic sweep(input string name);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      check(name, int'(rd_target), model[a]);
    end
  endtask

  task automatic run_frame();
    exp_t e;
    logic [7:0] first_hi;
    int a;
    predict(e);
    sb_q.push_back(e);
    foreach (frame_q[i]) send_byte(frame_q[i]);
    if (e.is_err) begin
      check("err_after_byte", int'(err), 1);
      check("err_busy_idle", int'(busy), 0);
      @(posedge clk); #1;
      check("err_one_cycle", int'(err), 0);
    end else begin
      first_hi = frame_q[2];
      a = int'(first_hi[7:4]);
      check("commit_in_ready", int'(in_ready), 0);
      check("commit_no_done_yet", int'(done), 0);
      rd_addr = 4'(a);
      #1;
      check("commit_cycle_old_value", int'(rd_target), model[a]);
      @(posedge clk); #1;
      check("done_pulse", int'(done), 1);
      check("done_cycle_new_value", int'(rd_target), e.tbl[a]);
      model = e.tbl;
      @(posedge clk); #1;
      check("done_one_cycle", int'(done), 0);
    end
    sweep("table_after_frame");
  endtask

  task automatic build_random(input int n, input bit bad_chk);
    logic [7:0] x, hi, lo;
    logic [9:0] tgt;
    logic [3:0] idx;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(n));
    x = 8'(n);
    for (int p = 0; p < n; p++) begin
      idx = 4'($urandom_range(0, 15));
      tgt = 10'($urandom_range(0, 1023));
      hi  = {idx, 2'($urandom_range(0, 3)), tgt[9:8]};
      lo  = tgt[7:0];
      frame_q.push_back(hi);
      frame_q.push_back(lo);
      x = x ^ hi ^ lo;
    end
    frame_q.push_back(bad_chk ? (x ^ 8'h01) : x);
  endtask

  // Scoreboard monitor: every done/err pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (reset_n && (done || err)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_done", int'(done), int'(!mon_e.is_err));
        check("sb_err", int'(err), int'(mon_e.is_err));
        if (done) begin
          check("sb_target", int'(rd_target), mon_e.tbl[rd_addr]);
          check("sb_loaded", int'(loaded), 1);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] g;
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_loaded", int'(loaded), 0);
    reset_n = 1'b1;
    sweep("rst_table");

    // Bad checksum: active bank untouched, no commit.
    frame_q = '{8'hA5, 8'h01, 8'h91, 8'h2C, 8'hBD};
    run_frame();
    check("bad_chk_not_loaded", int'(loaded), 0);

    // idx 9 -> 300.
    frame_q = '{8'hA5, 8'h01, 8'h91, 8'h2C, 8'hBC};
    run_frame();
    check("good_loaded", int'(loaded), 1);

    // Illegal counts abort right after COUNT.
    frame_q = '{8'hA5, 8'h00};
    run_frame();
    frame_q = '{8'hA5, 8'h11};
    run_frame();

    // Duplicate idx 3 (5 then 7), HI bits [3:2] set on the first pair.
    frame_q = '{8'hA5, 8'h02, 8'h3C, 8'h05, 8'h30, 8'h07, 8'h0C};
    run_frame();
    rd_addr = 4'd3; #1;
    check("dup_last_wins", int'(rd_target), 7);

    // SOF value inside the frame is plain data: idx 10 -> 0x1A5.
    frame_q = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h01};
    run_frame();

    // Idle garbage is dropped.
    for (int i = 0; i < 5; i++) begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g);
    end
    check("garbage_idle", int'(busy), 0);
    sweep("garbage_table");

    // Random frames, some with corrupted checksums and handshake gaps.
    for (int it = 0; it < 10; it++) begin
      use_gaps = 1'($urandom_range(0, 1));
      build_random($urandom_range(1, 16), ($urandom_range(0, 3) == 0));
      run_frame();
    end
    use_gaps = 1'b0;

    // Reset after the HI byte of a frame.
    frame_q = '{8'hA5, 8'h03, 8'h91};
    foreach (frame_q[i]) send_byte(frame_q[i]);
    check("midframe_busy", int'(busy), 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_loaded", int'(loaded), 0);
    reset_n = 1'b1;
    model_reset();
    sweep("midrst_table");

    // Same 16-entry frame with and without valid gaps must give the same table.
    build_random(16, 1'b0);
    saved_frame = frame_q;
    run_frame();
    saved_tbl = model;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    frame_q = saved_frame;
    use_gaps = 1'b1;
    run_frame();
    use_gaps = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      check("gap_table_equal", int'(rd_target), saved_tbl[a]);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
